// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, one stop bit, oversampled by CLKS_PER_BIT.
// Define UART_RX_PARITY_EN to add a parity bit (sense set by PARITY_ODD) and parity_error.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_enable,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       parity_error
);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("CLKS_PER_BIT out of range");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity
    $error("PARITY_ODD must be 0 or 1");
  end

  localparam logic [15:0] BitEnd  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfBit = 16'((CLKS_PER_BIT - 1) / 2);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
  localparam logic ParOdd = (PARITY_ODD != 0);
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;
`endif

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
  logic        par_err_q, par_err_d;
  logic        pe_q, pe_d;
`endif

  // Synchronizer resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    fe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
    pe_d      = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s && rx_enable) begin
          state_d   = StStart;
          bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      StStart: begin
        if (cnt_q == HalfBit) begin
          cnt_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == BitEnd) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == BitEnd) begin
          cnt_d     = '0;
          par_err_d = rx_s ^ (^shift_q) ^ ParOdd;
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == BitEnd) begin
          cnt_d = '0;
          if (!rx_s) begin
            fe_d    = 1'b1;
            state_d = StBreak;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_q) begin
            pe_d    = 1'b1;
            state_d = StIdle;
`endif
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
      pe_q      <= pe_d;
`endif
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_error = fe_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = pe_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, hand-written reset/glitch cases,
// and random frames checked against a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned Cpb  = 16;
  localparam int unsigned Podd = 0;
`ifdef UART_RX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_enable;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       parity_error;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(Cpb), .PARITY_ODD(Podd)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_enable    (rx_enable),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_error  (frame_error),
    .parity_error (parity_error)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_valid = 0, n_fe = 0, n_pe = 0, valid_cyc = 0, pulse_errs = 0;
  logic pv = 1'b0, pf = 1'b0, pp = 1'b0;
  int start_cyc = 0;
  logic [7:0] exp_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts output pulses, flags pulses longer than a cycle or overlapping.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid   <= n_valid + 1;
      valid_cyc <= cyc;
    end
    if (frame_error)  n_fe <= n_fe + 1;
    if (parity_error) n_pe <= n_pe + 1;
    if ((rx_valid && pv) || (frame_error && pf) || (parity_error && pp) ||
        (int'(rx_valid) + int'(frame_error) + int'(parity_error) > 1))
      pulse_errs <= pulse_errs + 1;
    pv <= rx_valid;
    pf <= frame_error;
    pp <= parity_error;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_cycles(Cpb);
  endtask

  function automatic logic good_parity(input logic [7:0] d);
    return (^d) ^ (Podd != 0);
  endfunction

  // Sends one frame; hold_low extra bit times of low follow the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input int hold_low, input int drop_bit);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_bit) rx_enable = 1'b0;
      drive_bit(d[i]);
    end
    if (ParEn) drive_bit(par_b);
    drive_bit(stop_b);
    for (int k = 0; k < hold_low; k++) drive_bit(1'b0);
    rx = 1'b1;
    wait_cycles(2 * Cpb);
  endtask

  task automatic frame_check(input string name, input logic [7:0] d, input logic stop_b,
                             input logic par_ok, input int hold_low, input int drop_bit,
                             input int e_valid, input int e_fe, input int e_pe,
                             input logic [7:0] e_data);
    int v0, f0, p0;
    v0 = n_valid; f0 = n_fe; p0 = n_pe;
    send_frame(d, stop_b, par_ok ? good_parity(d) : ~good_parity(d), hold_low, drop_bit);
    check({name, ".valid"}, n_valid - v0, e_valid);
    check({name, ".frame_err"}, n_fe - f0, e_fe);
    check({name, ".parity_err"}, n_pe - p0, e_pe);
    check({name, ".data"}, int'(rx_data), int'(e_data));
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop_b;
    logic       par_ok;
    int         hold_low;
    int         drop_bit;
    logic       en;
    logic       glitch;
    int         e_valid;
    int         e_fe;
    int         e_pe;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 0, -1, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
    tbl[1] = '{8'h3C, 1'b0, 1'b1, 2, -1, 1'b1, 1'b0, 0, 1, 0, 8'hA5};
    tbl[2] = '{8'h5A, 1'b1, 1'b1, 0, -1, 1'b1, 1'b1, 1, 0, 0, 8'h5A};
    tbl[3] = '{8'h11, 1'b1, 1'b1, 0, -1, 1'b0, 1'b0, 0, 0, 0, 8'h5A};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 0,  3, 1'b1, 1'b0, 1, 0, 0, 8'h5A};
    tbl[5] = '{8'h07, 1'b1, 1'b0, 0, -1, 1'b1, 1'b0, ParEn ? 0 : 1, 0, ParEn ? 1 : 0,
               ParEn ? 8'h5A : 8'h07};
    tbl[6] = '{8'h07, 1'b1, 1'b1, 0, -1, 1'b1, 1'b0, 1, 0, 0, 8'h07};

    rst = 1'b1; rx = 1'b1; rx_enable = 1'b1;
    wait_cycles(3);
    check("reset.data", int'(rx_data), 0);
    check("reset.valid", int'(rx_valid), 0);
    check("reset.frame_err", int'(frame_error), 0);
    check("reset.parity_err", int'(parity_error), 0);
    rst = 1'b0;
    wait_cycles(4);

    for (int i = 0; i < 7; i++) begin
      rx_enable = tbl[i].en;
      if (tbl[i].glitch) begin
        int v0, f0;
        v0 = n_valid; f0 = n_fe;
        rx = 1'b0; wait_cycles(4);
        rx = 1'b1; wait_cycles(2 * Cpb);
        check($sformatf("t%0d.glitch_valid", i), n_valid - v0, 0);
        check($sformatf("t%0d.glitch_fe", i), n_fe - f0, 0);
      end
      frame_check($sformatf("t%0d", i), tbl[i].d, tbl[i].stop_b, tbl[i].par_ok,
                  tbl[i].hold_low, tbl[i].drop_bit, tbl[i].e_valid, tbl[i].e_fe,
                  tbl[i].e_pe, tbl[i].e_data);
      // Valid lands half a start bit + 8 bits + stop sample after the edge, plus sync delay.
      if (i == 0) begin
        int lat;
        lat = valid_cyc - start_cyc - (ParEn ? int'(Cpb) : 0);
        check("t0.latency_ok", int'(lat >= 153 && lat <= 157), 1);
      end
      rx_enable = 1'b1;
    end
    exp_data = tbl[6].e_data;

    // Reset in the middle of data bit 4 discards the partial byte.
    begin
      logic [7:0] d;
      d = 8'hC3;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      rx = d[4];
      wait_cycles(Cpb / 2);
      rst = 1'b1;
      #1;
      check("rst_mid.data", int'(rx_data), 0);
      check("rst_mid.valid", int'(rx_valid), 0);
      check("rst_mid.frame_err", int'(frame_error), 0);
      check("rst_mid.parity_err", int'(parity_error), 0);
      rx = 1'b1;
      wait_cycles(3);
      rst = 1'b0;
      exp_data = 8'h00;
      wait_cycles(2 * Cpb);
      check("rst_mid.after_data", int'(rx_data), 0);
      frame_check("rst_next", 8'h0F, 1'b1, 1'b1, 0, -1, 1, 0, 0, 8'h0F);
      exp_data = 8'h0F;
    end

    // Random frames against the frame-level model.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic stop_b, par_ok;
      int e_valid, e_fe, e_pe;
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 4) != 0);
      par_ok = ($urandom_range(0, 3) != 0);
      e_valid = 0; e_fe = 0; e_pe = 0;
      if (!stop_b) e_fe = 1;
      else if (ParEn && !par_ok) e_pe = 1;
      else begin
        e_valid  = 1;
        exp_data = d;
      end
      frame_check($sformatf("rand%0d", n), d, stop_b, par_ok, 0, -1, e_valid, e_fe, e_pe,
                  exp_data);
    end

    check("pulse_shape_errors", pulse_errs, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 868, clk cycles per serial bit; legal 4..65535.
REQ-002 SHALL have parameter: PARITY_ODD, 0, parity sense when parity is compiled in (0 even, 1 odd).
REQ-003 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port: rx_enable  input  1  start-bit detection permitted when high.
REQ-007 SHALL have port: rx_data  output  8  last correctly received byte.
REQ-008 SHALL have port: rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-009 SHALL have port: frame_error  output  1  one-cycle pulse on stop bit sampled low.
REQ-010 SHALL have port: parity_error  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.

Function
REQ-011 SHALL pass rx through a two-flop synchronizer (rx_s) before any use; added latency 2 cycles.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
REQ-013 IDLE: SHALL go to START, with the bit counter cleared, when rx_s==0 and rx_enable==1; otherwise SHALL remain.
REQ-014 START: at counter==(CLKS_PER_BIT-1)/2 (integer division), SHALL go to DATA if rx_s==0, else to IDLE with no output pulse (glitch rejection).
REQ-015 DATA: SHALL sample rx_s at counter==CLKS_PER_BIT-1 and clear the counter; 8 samples, LSB first, shifted into a data register.
REQ-016 After the 8th data sample SHALL go to PARITY if compiled in, else STOP.
REQ-017 PARITY: SHALL sample one bit at counter==CLKS_PER_BIT-1, compare against XOR of data bits (XNOR when PARITY_ODD=1), latch the mismatch flag, then go to STOP.
REQ-018 STOP: at counter==CLKS_PER_BIT-1 with rx_s==1 and no parity mismatch, SHALL load rx_data, pulse rx_valid on the next cycle, and go to IDLE.
REQ-019 STOP with rx_s==1 and parity mismatch: SHALL pulse parity_error only; rx_data unchanged; rx_valid stays 0; go to IDLE.
REQ-020 STOP with rx_s==0: SHALL pulse frame_error only, regardless of parity; rx_data unchanged; go to BREAK.
REQ-021 BREAK: SHALL remain until rx_s==1, then go to IDLE, so that a held-low line never yields a byte.
REQ-022 rx_enable SHALL gate only the IDLE->START transition; deasserting it mid-frame SHALL NOT abort the frame.
REQ-023 Each of rx_valid, frame_error and parity_error SHALL be high for exactly one cycle per frame, and at most one of them SHALL be high per frame.
REQ-024 The bit counter SHALL be 16 bits wide and SHALL never wrap within a bit period.
REQ-025 rx_data SHALL hold its value between valid frames.

Reset
REQ-026 While rst is high, asynchronously: state=IDLE; rx_data=0; rx_valid=0; frame_error=0; parity_error=0; synchronizer flops=1; counters and shift register=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial byte; the first frame after release SHALL be received normally.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: frame is start + 8 data + parity + stop (11 bits); PARITY state and parity_error logic are present.
REQ-029 Macro UART_RX_PARITY_EN undefined: frame is start + 8 data + stop (10 bits); PARITY state is absent; parity_error is tied 0.

Verification (CLKS_PER_BIT=16, macro off unless stated)
REQ-030 Bench SHALL cover: frame 0xA5 with stop=1 and rx_enable=1 -> rx_valid high exactly 1 cycle, rx_data=0xA5, roughly 9.5 bit times + 3 cycles after the falling edge.
REQ-031 Bench SHALL cover: rx low for 4 cycles then high -> no rx_valid, no frame_error; a following 0x5A frame is received correctly.
REQ-032 Bench SHALL cover: frame 0x3C with stop=0, line held low 3 bit times -> one frame_error pulse, rx_valid=0, rx_data stays 0xA5, no further pulses until the line returns high.
REQ-033 Bench SHALL cover: rx_enable=0 at the start edge -> byte ignored; rx_enable dropped during bit 3 of 0x5A -> rx_valid pulses with rx_data=0x5A.
REQ-034 Bench SHALL cover: rst pulsed during data bit 4 -> all outputs 0 immediately; the next frame 0x0F gives rx_data=0x0F.
REQ-035 Bench SHALL cover, with UART_RX_PARITY_EN defined and PARITY_ODD=0: 0x07 sent with parity bit 0 -> parity_error pulse, no rx_valid; 0x07 sent with parity bit 1 -> rx_valid pulse, rx_data=0x07.
